// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding,
// default operand width and a counter-width helper.
package serial_adder_ctrl_pkg;

  // Default operand/result width.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. The encoding is fixed so that downstream debug
  // tooling can decode the state register directly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, for toolflows that lack $clog2 in constant contexts.
  // Never returns less than 1, so a counter declared with it is always legal.
  function automatic int cnt_width(input int w);
    int r;
    r = 1;
    while ((1 << r) < w) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// One-bit full-adder cell used by the serial adder for each bit pair.
module Fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  // Propagate term shared by sum and carry.
  assign half = a ^ b;
  assign sum  = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Accepts two WIDTH-bit operands plus a
// carry-in, feeds the full-adder cell one bit pair per clock (LSB first)
// with the carry held in a flip-flop, and collects the sum bits MSB-first
// into a shift register. Completion is flagged with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_sh_nxt;
  logic             carry_ff;
  logic [CNT_W-1:0] bit_cnt;

  logic             cell_sum;
  logic             cell_carry;
  logic             last_bit;
  logic             accept;

  // Per-bit arithmetic is done by the existing full-adder cell.
  Fulladder u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_ff),
    .sum  (cell_sum),
    .cout (cell_carry)
  );

  // The exit test is an explicit compare so the counter never has to wrap.
  assign last_bit = (bit_cnt == LAST_BIT);
  assign accept   = (state == ST_IDLE) && start;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign s_sh_nxt = {cell_sum, s_sh[WIDTH-1:1]};

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand shift registers, carry flip-flop and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      carry_ff <= 1'b0;
      bit_cnt  <= '0;
    end else if (accept) begin
      a_sh     <= a_in;
      b_sh     <= b_in;
      s_sh     <= '0;
      carry_ff <= cin;
      bit_cnt  <= '0;
    end else if (state == ST_SHIFT) begin
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      s_sh     <= s_sh_nxt;
      carry_ff <= cell_carry;
      if (!last_bit) begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end
    end
  end

  // Result registers load only on the final bit, so they hold between ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out <= '0;
      cout    <= 1'b0;
    end else if ((state == ST_SHIFT) && last_bit) begin
      sum_out <= s_sh_nxt;
      cout    <= cell_carry;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases on an 8-bit
// instance, then randomized back-to-back operations on 8- and 16-bit
// instances compared against a plain-arithmetic reference queue.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8;
  logic        start16;
  logic        cin;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;

  logic        ready8, busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        ready16, busy16, done16, cout16;
  logic [15:0] sum16;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .start   (start8),
    .a_in    (a8),
    .b_in    (b8),
    .cin     (cin),
    .ready   (ready8),
    .busy    (busy8),
    .sum_out (sum8),
    .cout    (cout8),
    .done    (done8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .start   (start16),
    .a_in    (a16),
    .b_in    (b16),
    .cin     (cin),
    .ready   (ready16),
    .busy    (busy16),
    .sum_out (sum16),
    .cout    (cout16),
    .done    (done16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One directed 8-bit operation from IDLE, checking latency and result.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    int         n;
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    check({tag, " ready before"}, 64'(ready8), 64'd1);
    a8 = a; b8 = b; cin = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin = 1'($urandom);
    n = 1;
    check({tag, " busy"}, 64'({busy8, ready8}), 64'b10);
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd9);
    check({tag, " result"}, 64'({cout8, sum8}), 64'(exp));
    tick();
    check({tag, " ready after"}, 64'({ready8, done8}), 64'b10);
  endtask

  // Back-to-back random operations with start held high.
  task automatic rand_run(input int w, input int nops);
    logic [32:0] q[$];
    logic [32:0] exp;
    logic [32:0] obs;
    logic [31:0] ra, rb;
    logic        rc, rdy_before, dn;
    int          ndone, cyc, last, limit;
    ndone = 0; cyc = 0; last = -1;
    limit = nops * (w + 2) + 100;
    start8  = (w == 8);
    start16 = (w == 16);
    while (ndone < nops && cyc < limit) begin
      rdy_before = (w == 8) ? ready8 : ready16;
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      a8 = ra[7:0]; b8 = rb[7:0]; a16 = ra[15:0]; b16 = rb[15:0]; cin = rc;
      tick();
      cyc++;
      if (rdy_before) begin
        if (w == 8) q.push_back(33'(ra[7:0]) + 33'(rb[7:0]) + 33'(rc));
        else        q.push_back(33'(ra[15:0]) + 33'(rb[15:0]) + 33'(rc));
      end
      dn = (w == 8) ? done8 : done16;
      if (dn) begin
        obs = (w == 8) ? 33'({cout8, sum8}) : 33'({cout16, sum16});
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        check($sformatf("rand w%0d op%0d", w, ndone), 64'(obs), 64'(exp));
        if (last >= 0) begin
          check($sformatf("rand w%0d spacing", w), 64'(cyc - last), 64'(w + 2));
        end
        last = cyc;
        ndone++;
      end
    end
    check($sformatf("rand w%0d completed", w), 64'(ndone), 64'(nops));
    start8 = 1'b0;
    start16 = 1'b0;
    repeat (w + 4) tick();
  endtask

  initial begin
    int       nd;
    logic [8:0] first_res;
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0; cin = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset w8 status", 64'({ready8, busy8, done8}), 64'b100);
    check("reset w8 result", 64'({cout8, sum8}), 64'd0);
    check("reset w16 status", 64'({ready16, busy16, done16}), 64'b100);
    check("reset w16 result", 64'({cout16, sum16}), 64'd0);

    op8(8'h00, 8'h00, 1'b0, "zero");
    op8(8'hFF, 8'h01, 1'b0, "ff+1");
    op8(8'h7F, 8'h01, 1'b0, "7f+1");
    op8(8'hA5, 8'h5A, 1'b1, "ripple");

    // start pulsed mid-operation must be ignored
    a8 = 8'h0F; b8 = 8'h01; cin = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    a8 = 8'h11; b8 = 8'h00; start8 = 1'b1;
    nd = 0;
    first_res = '0;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (done8) begin
        if (nd == 0) first_res = {cout8, sum8};
        nd++;
      end
      tick();
    end
    check("ignored start result", 64'(first_res), 64'h010);
    check("ignored start done count", 64'(nd), 64'd1);

    // reset in the middle of an operation discards it
    a8 = 8'h55; b8 = 8'h22; cin = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midreset status", 64'({ready8, busy8, done8}), 64'b100);
    check("midreset result", 64'({cout8, sum8}), 64'd0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) nd++;
      tick();
    end
    check("midreset no done", 64'(nd), 64'd0);
    op8(8'h3C, 8'h03, 1'b0, "after reset");

    rand_run(8, 500);
    rand_run(16, 500);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller; the stage directly upstream of the one-bit full-adder cell.
- Accepts two WIDTH-bit operands plus carry-in through a ready/start handshake.
- Feeds the cell one bit pair per clock, LSB first, with the carry held in a flip-flop between cycles.
- Collects the sum bits into a result register and reports completion with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high; sampled only on the rising edge of clk.
- start  input  1  request; sampled only when ready=1.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- ready  output  1  high only in IDLE.
- busy  output  1  high in SHIFT.
- sum_out  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered carry-out of the MSB.
- done  output  1  one-cycle pulse; sum_out and cout are valid in that cycle and afterwards.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; ready=1; busy=0; done=0.
  - sum_out=0; cout=0.
  - Shift registers, carry flip-flop and bit counter all cleared.
  - Reset has priority over every other event, including mid-operation: an operation in flight is discarded and produces no done.
- States: IDLE, SHIFT, DONE, 2-bit encoding.
- IDLE:
  - ready=1.
  - On an edge with start=1: capture a_in→a_sh, b_in→b_sh, cin→carry_ff; clear bit counter; clear s_sh; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, one bit per edge:
  - Cell inputs are a_sh[0], b_sh[0], carry_ff.
  - a_sh and b_sh shift right by 1.
  - The cell sum bit enters s_sh at the MSB, shifting s_sh right.
  - carry_ff ← cell carry.
  - Counter increments.
  - On the edge where the counter equals WIDTH-1: sum_out ← final s_sh (including this bit); cout ← cell carry; go to DONE.
- DONE: done=1 for exactly this one cycle; the next edge returns to IDLE.
- start is ignored outside IDLE; no queuing.
- Latency:
  - Accepting edge k; bits processed on edges k+1..k+WIDTH.
  - done is high during the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance.
  - ready returns after edge k+WIDTH+1.
  - Throughput: one operation per WIDTH+2 cycles.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, computed modulo 2^(WIDTH+1); it never saturates.
- Counter width is $clog2(WIDTH). The counter never wraps inside an operation, because the exit condition is an explicit compare to WIDTH-1.
- Operands may change freely after the accepting edge without affecting the result.
- sum_out and cout change only on DONE entry or on reset; they hold between operations.
- start=1 held continuously: a new operation begins on every IDLE edge, so back-to-back operations have one IDLE cycle between them.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - default WIDTH constant.
  - $clog2-based counter-width function, if the toolflow lacks $clog2.
- One sub-module is natural: instantiate the existing one-bit full-adder cell (Fulladder) for the per-bit sum/carry.
- The controller holds only the FSM, the shift registers, the carry flip-flop and the counter.

Test Plan:
- Reset, then a=8'h00, b=8'h00, cin=0 → done exactly 9 cycles after acceptance; sum_out=8'h00, cout=0; ready back 1 cycle later.
- a=8'hFF, b=8'h01, cin=0 → sum_out=8'h00, cout=1; a=8'h7F, b=8'h01, cin=0 → sum_out=8'h80, cout=0.
- a=8'hA5, b=8'h5A, cin=1 → sum_out=8'h00, cout=1; the full carry ripple crosses all 8 bits.
- Pulse start=1 with a=8'h11 at cycle 3 of an active operation (a=8'h0F, b=8'h01) → ignored; result 8'h10, cout=0; only one done pulse.
- Assert rst for one edge at bit 4 of an operation → next cycle ready=1, sum_out=0, cout=0, no done. A following operation 8'h3C+8'h03 → 8'h3F.
- 1000 random operations with start held high, WIDTH=8 and WIDTH=16 → each {cout,sum_out} equals a+b+cin; done spacing equals WIDTH+2 cycles.
